bayer_wb_gain: RTL and testbench
================================

Name: bayer_wb_gain

Overview:
- Per-channel digital white-balance gain stage for raw Bayer video.
- Sits directly downstream of black level calibration: takes black-corrected pixels and multiplies each by the gain of its Bayer colour channel (R, Gr, Gb, B), with rounding and saturation.
- Tracks Bayer phase from tuser/tlast, double-buffers gains so they change only on frame boundaries, and reports a per-frame saturated-pixel count.

Parameters:
- PX_WIDTH, 10, pixel bit width.
- FRAME_RES_X, 1920, active pixels per line; sizes counters only.
- FRAME_RES_Y, 1080, active lines per frame; sizes counters only.
- GAIN_WIDTH, 12, unsigned fixed-point gain width.
- GAIN_FRAC, 8, fractional bits of gain; 1.0 = 2^GAIN_FRAC. Legal range 0..GAIN_WIDTH-1.
- BAYER_PATTERN, 0, channel at (row 0, col 0): 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, reset; synchronous, active-high.
- bypass_i, input, 1, level; 1 = pass pixels unmodified (latency unchanged).
- cfg_stb_i, input, 1, one-cycle strobe; captures gain_*_i into the pending registers.
- gain_r_i, input, GAIN_WIDTH, R gain.
- gain_gr_i, input, GAIN_WIDTH, Gr gain.
- gain_gb_i, input, GAIN_WIDTH, Gb gain.
- gain_b_i, input, GAIN_WIDTH, B gain.
- sat_cnt_o, output, clog2(FRAME_RES_X*FRAME_RES_Y+1), saturated pixels in the last completed frame.
- video_i, axi4_stream_if.slave, TDATA_WIDTH = PX_WIDTH rounded up to a byte multiple. Pixel in [PX_WIDTH-1:0]; tuser = start of frame, tlast = end of line.
- video_o, axi4_stream_if.master, same width. Unused upper tdata bits are 0.

Behaviour:
- Reset (synchronous, rst_i high at a clk_i edge):
  - video_o.tvalid/tdata/tstrb/tkeep/tlast/tuser/tid/tdest = 0.
  - pending and active gains = 2^GAIN_FRAC (1.0).
  - row/col phase = 0; saturation counter and sat_cnt_o = 0.
  - Pipeline contents are discarded when reset is asserted mid-frame.
- Handshake:
  - en = !video_o.tvalid || video_o.tready; video_i.tready = en.
  - All pipeline registers advance only when en = 1.
  - Bubbles (tvalid = 0) propagate through the pipeline.
  - video_o holds all fields stable while tvalid && !tready.
- Latency: exactly 2 enabled cycles, input beat to output beat. Sideband fields (tstrb, tkeep, tlast, tuser, tid, tdest) are delayed alongside tdata.
- Bayer phase, updated on each accepted beat (tvalid && tready):
  - A tuser beat has phase (0,0).
  - After a beat with tlast: col = 0 and row toggles.
  - Otherwise col toggles.
  - Channel = BAYER_PATTERN mapping of {row,col}. For RGGB: (0,0) R, (0,1) Gr, (1,0) Gb, (1,1) B.
  - A tuser beat resets the phase even if the previous frame was truncated.
- Gain double-buffering:
  - cfg_stb_i writes pending gains.
  - An accepted tuser beat copies pending into active, and that beat already uses the new gains.
  - cfg_stb_i in the same cycle as an accepted tuser beat: active takes the old pending values; the new values take effect at the next frame.
- Stage 1 registers the pixel, the selected active gain and the sideband fields.
- Stage 2 arithmetic:
  - prod = px * gain, width PX_WIDTH+GAIN_WIDTH.
  - r = (prod + (GAIN_FRAC ? 2^(GAIN_FRAC-1) : 0)) >> GAIN_FRAC.
  - out = r > 2^PX_WIDTH-1 ? 2^PX_WIDTH-1 : r; set sat = 1 when clamped.
  - When bypass_i is sampled high at stage 1: out = px and sat = 0.
  - Gain 0 gives out = 0.
- Saturation count, evaluated per beat leaving stage 2 (output register load with valid):
  - If the beat has tuser: sat_cnt_o <= counter, and counter <= sat.
  - Otherwise: counter += sat, saturating at its maximum value.
  - The first frame after reset reports 0.

Decomposition:
- Package wb_gain_pkg holds:
  - enum bayer_ch_t {CH_R, CH_GR, CH_GB, CH_B};
  - BAYER_PATTERN encodings RGGB/GRBG/GBRG/BGGR;
  - function phase_to_ch(pattern, row, col).
- One sub-module, bayer_phase_tracker: consumes valid/ready/tuser/tlast and outputs bayer_ch_t for the current input beat.
- Multiply, round and saturate stay inline in bayer_wb_gain.

Test Plan:
- RGGB, gains R = 0x200 (2.0), Gr = Gb = 0x100, B = 0x080 (0.5), constant pixel 100, 4x2 frame, tready = 1:
  - line 0 outputs 200,100,200,100; line 1 outputs 100,50,100,50;
  - each output appears 2 cycles after its input.
- Pixel 1000, R gain 0x180 (1.5) → output 1023; 3 saturating pixels in frame N → sat_cnt_o = 3 after the tuser beat of frame N+1 exits.
- Pixel 3, gain 0x0C0 (0.75) → 2.25 → output 2; pixel 2, gain 0x0C0 → 1.5 → output 2 (round half up).
- cfg_stb_i with R = 0x200 mid-frame → current frame still uses 1.0; the tuser beat of the next frame gives 2x.
- cfg_stb_i coincident with an accepted tuser beat → that frame keeps the old pending gains.
- Random tready/tvalid backpressure over 3 frames compared against a scoreboard → no loss, duplication or reordering; video_o stable while stalled.
- rst_i asserted mid-frame → tvalid = 0 the next cycle, gains = 1.0; a new frame after reset starts at phase (0,0).

Source files
------------

// File: rtl/wb_gain_pkg.sv
// -----------------------------------------------------------------------------
// wb_gain_pkg
// Shared types and helpers for the Bayer white-balance gain stage.
//   bayer_ch_t   : colour channel of a Bayer site (R, Gr, Gb, B)
//   BAYER_*      : encodings of the channel found at (row 0, col 0)
//   AXIS_*_W     : default tid/tdest widths of the video stream interface
//   phase_to_ch  : maps a pattern plus a (row, col) phase to a channel
// -----------------------------------------------------------------------------
package wb_gain_pkg;

   // Encoded so that {row, col} of an RGGB mosaic is the enum value itself.
   typedef enum logic [1:0] {
      CH_R  = 2'd0,
      CH_GR = 2'd1,
      CH_GB = 2'd2,
      CH_B  = 2'd3
   } bayer_ch_t;

   localparam int BAYER_RGGB = 0;
   localparam int BAYER_GRBG = 1;
   localparam int BAYER_GBRG = 2;
   localparam int BAYER_BGGR = 3;

   localparam int AXIS_ID_W   = 4;
   localparam int AXIS_DEST_W = 4;

   // Every other pattern is RGGB shifted by one column (bit 0) and/or one
   // row (bit 1), so flipping the phase bits re-uses the RGGB mapping.
   function automatic bayer_ch_t phase_to_ch(input int pattern, input logic row, input logic col);
      logic [1:0] idx;
      idx = {row ^ pattern[1], col ^ pattern[0]};
      return bayer_ch_t'(idx);
   endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// -----------------------------------------------------------------------------
// axi4_stream_if
// Minimal AXI4-Stream bundle used for the video ports.
//   tvalid/tready : handshake
//   tdata         : TDATA_WIDTH bits, tstrb/tkeep one bit per byte
//   tlast/tuser   : end of line / start of frame
//   tid/tdest     : routing sideband, carried through unchanged
// Modports: master drives everything except tready, slave drives tready.
// -----------------------------------------------------------------------------
interface axi4_stream_if #(
   parameter int TDATA_WIDTH = 16,
   parameter int TID_WIDTH   = wb_gain_pkg::AXIS_ID_W,
   parameter int TDEST_WIDTH = wb_gain_pkg::AXIS_DEST_W
);
   localparam int TSTRB_WIDTH = TDATA_WIDTH / 8;

   logic                   tvalid;
   logic                   tready;
   logic [TDATA_WIDTH-1:0] tdata;
   logic [TSTRB_WIDTH-1:0] tstrb;
   logic [TSTRB_WIDTH-1:0] tkeep;
   logic                   tlast;
   logic                   tuser;
   logic [TID_WIDTH-1:0]   tid;
   logic [TDEST_WIDTH-1:0] tdest;

   modport master (
      output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
      output tready
   );

endinterface

// File: rtl/bayer_phase_tracker.sv
// -----------------------------------------------------------------------------
// bayer_phase_tracker
// Follows the row/column parity of the incoming Bayer stream and reports the
// colour channel of the beat currently presented on the input.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_valid, i_ready   : input handshake; the phase moves on accepted beats
//   i_tuser, i_tlast   : start of frame / end of line of the current beat
//   o_ch               : channel of the current beat (combinational)
// -----------------------------------------------------------------------------
module bayer_phase_tracker
   import wb_gain_pkg::*;
#(
   parameter int BAYER_PATTERN = BAYER_RGGB
) (
   input  logic      i_clk,
   input  logic      i_rst,
   input  logic      i_valid,
   input  logic      i_ready,
   input  logic      i_tuser,
   input  logic      i_tlast,
   output bayer_ch_t o_ch
);

   logic r_row;
   logic r_col;
   logic w_row;
   logic w_col;
   logic w_accept;

   // A start-of-frame beat is always site (0,0), whatever phase a truncated
   // previous frame left behind, so it overrides the stored phase.
   always_comb begin
      w_row = r_row;
      w_col = r_col;
      if (i_tuser) begin
         w_row = 1'b0;
         w_col = 1'b0;
      end
   end

   assign w_accept = i_valid && i_ready;
   assign o_ch     = phase_to_ch(BAYER_PATTERN, w_row, w_col);

   // Advance from the phase of the beat just accepted: end of line wraps to
   // column 0 of the other row parity, anything else steps one column.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_row <= 1'b0;
         r_col <= 1'b0;
      end else if (w_accept) begin
         if (i_tlast) begin
            r_row <= ~w_row;
            r_col <= 1'b0;
         end else begin
            r_row <= w_row;
            r_col <= ~w_col;
         end
      end
   end

endmodule

// File: rtl/bayer_wb_gain.sv
// -----------------------------------------------------------------------------
// bayer_wb_gain
// Per-channel white-balance gain for raw Bayer video, two-stage pipeline.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   bypass_i              : 1 = pixels pass unmodified (same latency)
//   cfg_stb_i             : strobe, captures gain_*_i into the pending set
//   gain_r/gr/gb/b_i      : unsigned fixed-point gains, GAIN_FRAC fraction bits
//   sat_cnt_o             : clamped pixels counted over the last full frame
//   video_i               : AXI4-Stream slave, pixel in tdata[PX_WIDTH-1:0],
//                           tuser = start of frame, tlast = end of line
//   video_o               : AXI4-Stream master, same format, upper bits zero
// -----------------------------------------------------------------------------
module bayer_wb_gain
   import wb_gain_pkg::*;
#(
   parameter int PX_WIDTH      = 10,
   parameter int FRAME_RES_X   = 1920,
   parameter int FRAME_RES_Y   = 1080,
   parameter int GAIN_WIDTH    = 12,
   parameter int GAIN_FRAC     = 8,
   parameter int BAYER_PATTERN = BAYER_RGGB
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  bypass_i,
   input  logic                  cfg_stb_i,
   input  logic [GAIN_WIDTH-1:0] gain_r_i,
   input  logic [GAIN_WIDTH-1:0] gain_gr_i,
   input  logic [GAIN_WIDTH-1:0] gain_gb_i,
   input  logic [GAIN_WIDTH-1:0] gain_b_i,
   output logic [$clog2(FRAME_RES_X*FRAME_RES_Y+1)-1:0] sat_cnt_o,
   axi4_stream_if.slave          video_i,
   axi4_stream_if.master         video_o
);

   localparam int TDATA_W = ((PX_WIDTH + 7) / 8) * 8;
   localparam int TKEEP_W = TDATA_W / 8;
   localparam int PROD_W  = PX_WIDTH + GAIN_WIDTH;
   localparam int SAT_W   = $clog2(FRAME_RES_X*FRAME_RES_Y+1);

   localparam logic [GAIN_WIDTH-1:0] GAIN_ONE  = GAIN_WIDTH'(1 << GAIN_FRAC);
   localparam logic [PROD_W-1:0]     ROUND_ADD = PROD_W'((1 << GAIN_FRAC) >> 1);
   localparam logic [PROD_W-1:0]     PX_MAX    = {{GAIN_WIDTH{1'b0}}, {PX_WIDTH{1'b1}}};
   localparam logic [SAT_W-1:0]      SAT_MAX   = {SAT_W{1'b1}};
   localparam logic [SAT_W-1:0]      SAT_ONE   = SAT_W'(1);

   logic w_en;
   logic w_accept;
   logic w_sofAccept;
   bayer_ch_t w_ch;

   logic [GAIN_WIDTH-1:0] r_pendR, r_pendGr, r_pendGb, r_pendB;
   logic [GAIN_WIDTH-1:0] r_actR, r_actGr, r_actGb, r_actB;
   logic [GAIN_WIDTH-1:0] w_gainSel;

   logic                   r_s1Valid;
   logic [PX_WIDTH-1:0]    r_s1Px;
   logic [GAIN_WIDTH-1:0]  r_s1Gain;
   logic                   r_s1Bypass;
   logic [TKEEP_W-1:0]     r_s1Strb, r_s1Keep;
   logic                   r_s1Last, r_s1User;
   logic [AXIS_ID_W-1:0]   r_s1Id;
   logic [AXIS_DEST_W-1:0] r_s1Dest;

   logic [PROD_W-1:0]      w_prod, w_sum, w_rounded;
   logic [PX_WIDTH-1:0]    w_outPx;
   logic                   w_sat;
   logic [TDATA_W-1:0]     w_outData;

   logic                   r_s2Valid;
   logic [TDATA_W-1:0]     r_s2Data;
   logic [TKEEP_W-1:0]     r_s2Strb, r_s2Keep;
   logic                   r_s2Last, r_s2User;
   logic [AXIS_ID_W-1:0]   r_s2Id;
   logic [AXIS_DEST_W-1:0] r_s2Dest;

   logic [SAT_W-1:0]       r_satCount;
   logic [SAT_W-1:0]       r_satReport;
   logic                   w_unusedTdata;

   // The whole pipeline stalls together whenever the output holds a beat
   // the downstream has not taken yet.
   assign w_en          = !r_s2Valid || video_o.tready;
   assign video_i.tready = w_en;
   assign w_accept      = video_i.tvalid && w_en;
   assign w_sofAccept   = w_accept && video_i.tuser;

   generate
      if (TDATA_W > PX_WIDTH) begin : g_padBits
         assign w_unusedTdata = ^video_i.tdata[TDATA_W-1:PX_WIDTH];
      end else begin : g_noPadBits
         assign w_unusedTdata = 1'b0;
      end
   endgenerate

   bayer_phase_tracker #(
      .BAYER_PATTERN (BAYER_PATTERN)
   ) u_phase (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_valid (video_i.tvalid),
      .i_ready (w_en),
      .i_tuser (video_i.tuser),
      .i_tlast (video_i.tlast),
      .o_ch    (w_ch)
   );

   // Gains are double-buffered: a strobe only touches the pending set, and
   // the start-of-frame beat copies pending into active. A strobe landing on
   // that same beat therefore only reaches the frame after.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pendR  <= GAIN_ONE;
         r_pendGr <= GAIN_ONE;
         r_pendGb <= GAIN_ONE;
         r_pendB  <= GAIN_ONE;
         r_actR   <= GAIN_ONE;
         r_actGr  <= GAIN_ONE;
         r_actGb  <= GAIN_ONE;
         r_actB   <= GAIN_ONE;
      end else begin
         if (cfg_stb_i) begin
            r_pendR  <= gain_r_i;
            r_pendGr <= gain_gr_i;
            r_pendGb <= gain_gb_i;
            r_pendB  <= gain_b_i;
         end
         if (w_sofAccept) begin
            r_actR  <= r_pendR;
            r_actGr <= r_pendGr;
            r_actGb <= r_pendGb;
            r_actB  <= r_pendB;
         end
      end
   end

   // The start-of-frame beat must already see the gains it is promoting, so
   // it reads straight from the pending set instead of the active one.
   always_comb begin
      w_gainSel = r_actR;
      case (w_ch)
         CH_R:    w_gainSel = w_sofAccept ? r_pendR  : r_actR;
         CH_GR:   w_gainSel = w_sofAccept ? r_pendGr : r_actGr;
         CH_GB:   w_gainSel = w_sofAccept ? r_pendGb : r_actGb;
         CH_B:    w_gainSel = w_sofAccept ? r_pendB  : r_actB;
         default: w_gainSel = r_actR;
      endcase
   end

   // Stage 1 captures the pixel with its gain, bypass flag and sideband;
   // bubbles are loaded too so they keep their slot in the pipeline.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1Valid  <= 1'b0;
         r_s1Px     <= '0;
         r_s1Gain   <= '0;
         r_s1Bypass <= 1'b0;
         r_s1Strb   <= '0;
         r_s1Keep   <= '0;
         r_s1Last   <= 1'b0;
         r_s1User   <= 1'b0;
         r_s1Id     <= '0;
         r_s1Dest   <= '0;
      end else if (w_en) begin
         r_s1Valid  <= video_i.tvalid;
         r_s1Px     <= video_i.tdata[PX_WIDTH-1:0];
         r_s1Gain   <= w_gainSel;
         r_s1Bypass <= bypass_i;
         r_s1Strb   <= video_i.tstrb;
         r_s1Keep   <= video_i.tkeep;
         r_s1Last   <= video_i.tlast;
         r_s1User   <= video_i.tuser;
         r_s1Id     <= video_i.tid;
         r_s1Dest   <= video_i.tdest;
      end
   end

   // Multiply, round half up, then clamp to full scale. The product plus
   // the rounding constant cannot exceed PROD_W bits, so no carry is lost.
   always_comb begin
      w_prod    = PROD_W'(r_s1Px) * PROD_W'(r_s1Gain);
      w_sum     = w_prod + ROUND_ADD;
      w_rounded = w_sum >> GAIN_FRAC;
      w_sat     = 1'b0;
      w_outPx   = w_rounded[PX_WIDTH-1:0];
      if (r_s1Bypass) begin
         w_outPx = r_s1Px;
      end else if (w_rounded > PX_MAX) begin
         w_outPx = {PX_WIDTH{1'b1}};
         w_sat   = 1'b1;
      end
      w_outData                 = '0;
      w_outData[PX_WIDTH-1:0]   = w_outPx;
   end

   // Stage 2 is the output register; it only moves when downstream can
   // accept, which keeps every field frozen during a stall.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s2Valid <= 1'b0;
         r_s2Data  <= '0;
         r_s2Strb  <= '0;
         r_s2Keep  <= '0;
         r_s2Last  <= 1'b0;
         r_s2User  <= 1'b0;
         r_s2Id    <= '0;
         r_s2Dest  <= '0;
      end else if (w_en) begin
         r_s2Valid <= r_s1Valid;
         r_s2Data  <= w_outData;
         r_s2Strb  <= r_s1Strb;
         r_s2Keep  <= r_s1Keep;
         r_s2Last  <= r_s1Last;
         r_s2User  <= r_s1User;
         r_s2Id    <= r_s1Id;
         r_s2Dest  <= r_s1Dest;
      end
   end

   // Count clamped pixels as they enter the output register. A new frame
   // publishes the finished count and restarts it with its own first pixel.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_satCount  <= '0;
         r_satReport <= '0;
      end else if (w_en && r_s1Valid) begin
         if (r_s1User) begin
            r_satReport <= r_satCount;
            r_satCount  <= w_sat ? SAT_ONE : '0;
         end else if (w_sat && (r_satCount != SAT_MAX)) begin
            r_satCount  <= r_satCount + SAT_ONE;
         end
      end
   end

   assign sat_cnt_o      = r_satReport;
   assign video_o.tvalid = r_s2Valid;
   assign video_o.tdata  = r_s2Data;
   assign video_o.tstrb  = r_s2Strb;
   assign video_o.tkeep  = r_s2Keep;
   assign video_o.tlast  = r_s2Last;
   assign video_o.tuser  = r_s2User;
   assign video_o.tid    = r_s2Id;
   assign video_o.tdest  = r_s2Dest;

endmodule

// File: tb/tb_bayer_wb_gain.sv
// -----------------------------------------------------------------------------
// tb_bayer_wb_gain
// Directed bench for bayer_wb_gain (RGGB, 10-bit pixels, 4.8 gains).
// Expected beats are queued by the stimulus and compared as they leave.
// -----------------------------------------------------------------------------
module tb_bayer_wb_gain;

   typedef struct {
      logic [15:0] data;
      logic        user;
      logic        last;
      logic [3:0]  id;
      logic [3:0]  dest;
   } beat_t;

   logic        clock;
   logic        reset;
   logic        bypass;
   logic        cfgStb;
   logic [11:0] gainR, gainGr, gainGb, gainB;
   logic [20:0] satCnt;

   axi4_stream_if #(.TDATA_WIDTH(16)) vin ();
   axi4_stream_if #(.TDATA_WIDTH(16)) vout ();

   int    assertCount = 0;
   int    failCount   = 0;
   int    cycleCnt    = 0;
   bit    monitorEnable = 1'b0;
   bit    checkLatency  = 1'b1;
   bit    randReady     = 1'b0;
   bit    prevStall     = 1'b0;
   logic [31:0] prevFields;
   beat_t monBeat;
   beat_t expQ[$];
   int    inCycles[$];

   bayer_wb_gain #(
      .PX_WIDTH      (10),
      .FRAME_RES_X   (1920),
      .FRAME_RES_Y   (1080),
      .GAIN_WIDTH    (12),
      .GAIN_FRAC     (8),
      .BAYER_PATTERN (0)
   ) dut (
      .clk_i     (clock),
      .rst_i     (reset),
      .bypass_i  (bypass),
      .cfg_stb_i (cfgStb),
      .gain_r_i  (gainR),
      .gain_gr_i (gainGr),
      .gain_gb_i (gainGb),
      .gain_b_i  (gainB),
      .sat_cnt_o (satCnt),
      .video_i   (vin),
      .video_o   (vout)
   );

   // Free-running clock and a cycle counter used for latency checks.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cycleCnt <= cycleCnt + 1;

   // Downstream ready changes just after the rising edge so that everything
   // the bench looks at on the falling edge is settled.
   always @(posedge clock) begin
      #1;
      vout.tready = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Output monitor: pops the scoreboard on every transferred beat and
   // checks that a stalled beat does not change while it waits.
   always @(negedge clock) begin
      if (!monitorEnable || reset) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall)
            checkOutput("stall_hold", {5'd0, vout.tvalid, vout.tdata, vout.tuser, vout.tlast, vout.tid, vout.tdest}, prevFields);
         if (vout.tvalid && vout.tready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_beat", 32'd1, 32'd0);
            end else begin
               monBeat = expQ.pop_front();
               checkOutput("out_data", {16'd0, vout.tdata}, {16'd0, monBeat.data});
               checkOutput("out_user", {31'd0, vout.tuser}, {31'd0, monBeat.user});
               checkOutput("out_last", {31'd0, vout.tlast}, {31'd0, monBeat.last});
               checkOutput("out_side", {20'd0, vout.tstrb, vout.tkeep, vout.tid, vout.tdest},
                           {20'd0, 2'b11, 2'b11, monBeat.id, monBeat.dest});
               if (inCycles.size() > 0) begin
                  int c;
                  c = inCycles.pop_front();
                  if (checkLatency) checkOutput("latency", 32'(cycleCnt - c), 32'd2);
               end
            end
         end
         prevStall  = vout.tvalid && !vout.tready;
         prevFields = {5'd0, vout.tvalid, vout.tdata, vout.tuser, vout.tlast, vout.tid, vout.tdest};
      end
   end

   // Presents one beat from a falling edge and holds it until accepted.
   task automatic applyStimulus(input logic [9:0] px, input logic user, input logic last, input logic strobe);
      int guard;
      @(negedge clock);
      vin.tvalid = 1'b1;
      vin.tdata  = {6'd0, px};
      vin.tstrb  = 2'b11;
      vin.tkeep  = 2'b11;
      vin.tuser  = user;
      vin.tlast  = last;
      vin.tid    = px[3:0];
      vin.tdest  = ~px[3:0];
      cfgStb     = strobe;
      guard      = 0;
      while (!vin.tready && guard < 1000) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 1000) checkOutput("accept_timeout", 32'(guard), 32'd0);
      if (monitorEnable) inCycles.push_back(cycleCnt);
      @(posedge clock);
      #1;
      vin.tvalid = 1'b0;
      vin.tuser  = 1'b0;
      vin.tlast  = 1'b0;
      cfgStb     = 1'b0;
   endtask

   task automatic sendBeat(input logic [9:0] px, input logic user, input logic last, input int expPx, input logic strobe = 1'b0);
      beat_t b;
      b.data = 16'(expPx);
      b.user = user;
      b.last = last;
      b.id   = px[3:0];
      b.dest = ~px[3:0];
      expQ.push_back(b);
      applyStimulus(px, user, last, strobe);
   endtask

   task automatic setGains(input logic [11:0] r, input logic [11:0] gr, input logic [11:0] gb, input logic [11:0] b);
      @(negedge clock);
      gainR  = r;
      gainGr = gr;
      gainGb = gb;
      gainB  = b;
      cfgStb = 1'b1;
      @(posedge clock);
      #1;
      cfgStb = 1'b0;
   endtask

   task automatic drain(input int maxCycles);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < maxCycles) begin
         @(negedge clock);
         n++;
      end
      if (expQ.size() != 0) begin
         checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
         expQ.delete();
         inCycles.delete();
      end
      repeat (2) @(negedge clock);
   endtask

   function automatic int modelPx(input int px, input int gain);
      int r;
      r = (px * gain + 128) >>> 8;
      return (r > 1023) ? 1023 : r;
   endfunction

   initial begin
      reset      = 1'b1;
      bypass     = 1'b0;
      cfgStb     = 1'b0;
      gainR      = 12'h100;
      gainGr     = 12'h100;
      gainGb     = 12'h100;
      gainB      = 12'h100;
      vin.tvalid = 1'b0;
      vin.tdata  = '0;
      vin.tstrb  = '0;
      vin.tkeep  = '0;
      vin.tuser  = 1'b0;
      vin.tlast  = 1'b0;
      vin.tid    = '0;
      vin.tdest  = '0;

      // Reset state of every output field and of the saturation report.
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_tvalid", {31'd0, vout.tvalid}, 32'd0);
      checkOutput("rst_tdata",  {16'd0, vout.tdata}, 32'd0);
      checkOutput("rst_tuser_tlast", {30'd0, vout.tuser, vout.tlast}, 32'd0);
      checkOutput("rst_sat_cnt", {11'd0, satCnt}, 32'd0);
      reset = 1'b0;
      monitorEnable = 1'b1;

      // Unity gain straight after reset.
      sendBeat(10'd77, 1'b1, 1'b1, 77);
      drain(50);

      // 4x2 frame, R 2.0, G 1.0, B 0.5, constant 100.
      setGains(12'h200, 12'h100, 12'h100, 12'h080);
      sendBeat(10'd100, 1'b1, 1'b0, 200);
      sendBeat(10'd100, 1'b0, 1'b0, 100);
      sendBeat(10'd100, 1'b0, 1'b0, 200);
      sendBeat(10'd100, 1'b0, 1'b1, 100);
      sendBeat(10'd100, 1'b0, 1'b0, 100);
      sendBeat(10'd100, 1'b0, 1'b0, 50);
      sendBeat(10'd100, 1'b0, 1'b0, 100);
      sendBeat(10'd100, 1'b0, 1'b1, 50);
      drain(50);

      // Frame N: R 1.5 on pixel 1000 clamps three times; a mid-frame strobe
      // must not disturb the rest of the frame.
      setGains(12'h180, 12'h100, 12'h100, 12'h100);
      sendBeat(10'd1000, 1'b1, 1'b0, 1023);
      setGains(12'h0C0, 12'h0C0, 12'h000, 12'h100);
      sendBeat(10'd1000, 1'b0, 1'b0, 1000);
      sendBeat(10'd1000, 1'b0, 1'b0, 1023);
      sendBeat(10'd1000, 1'b0, 1'b0, 1000);
      sendBeat(10'd1000, 1'b0, 1'b0, 1023);
      sendBeat(10'd1000, 1'b0, 1'b1, 1000);
      drain(50);
      checkOutput("sat_cnt_frame_n", {11'd0, satCnt}, 32'd0);

      // Frame N+1: rounding (2.25 -> 2, 1.5 -> 2), zero gain, full scale.
      sendBeat(10'd3,    1'b1, 1'b0, 2);
      sendBeat(10'd2,    1'b0, 1'b1, 2);
      sendBeat(10'd500,  1'b0, 1'b0, 0);
      sendBeat(10'd1023, 1'b0, 1'b1, 1023);
      drain(50);
      checkOutput("sat_cnt_frame_n1", {11'd0, satCnt}, 32'd3);

      // Frame M: strobe coincident with the start-of-frame beat keeps the
      // old pending (unity) gains for the whole frame.
      setGains(12'h100, 12'h100, 12'h100, 12'h100);
      @(negedge clock);
      gainR  = 12'h200;
      gainGr = 12'h100;
      gainGb = 12'h100;
      gainB  = 12'h100;
      sendBeat(10'd100, 1'b1, 1'b0, 100, 1'b1);
      sendBeat(10'd100, 1'b0, 1'b0, 100);
      sendBeat(10'd100, 1'b0, 1'b0, 100);
      sendBeat(10'd100, 1'b0, 1'b1, 100);
      drain(50);
      checkOutput("sat_cnt_frame_m", {11'd0, satCnt}, 32'd0);

      // Frame M+1: new gains from the first beat, one bypassed pixel that
      // would clamp and one real clamp.
      sendBeat(10'd100, 1'b1, 1'b0, 200);
      sendBeat(10'd9,   1'b0, 1'b0, 9);
      bypass = 1'b1;
      sendBeat(10'd1000, 1'b0, 1'b0, 1000);
      bypass = 1'b0;
      sendBeat(10'd700,  1'b0, 1'b0, 700);
      sendBeat(10'd1000, 1'b0, 1'b0, 1023);
      sendBeat(10'd1,    1'b0, 1'b1, 1);
      drain(50);
      sendBeat(10'd100, 1'b1, 1'b0, 200);
      sendBeat(10'd10,  1'b0, 1'b1, 10);
      drain(50);
      checkOutput("sat_cnt_bypass", {11'd0, satCnt}, 32'd1);

      // Reset in the middle of a frame while beats are in flight.
      monitorEnable = 1'b0;
      applyStimulus(10'd100, 1'b1, 1'b0, 1'b0);
      applyStimulus(10'd100, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      checkOutput("pre_reset_tvalid", {31'd0, vout.tvalid}, 32'd1);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("mid_reset_tvalid", {31'd0, vout.tvalid}, 32'd0);
      checkOutput("mid_reset_sat_cnt", {11'd0, satCnt}, 32'd0);
      reset = 1'b0;
      expQ.delete();
      inCycles.delete();
      monitorEnable = 1'b1;
      sendBeat(10'd100, 1'b1, 1'b0, 100);
      sendBeat(10'd100, 1'b0, 1'b1, 100);
      sendBeat(10'd100, 1'b0, 1'b0, 100);
      sendBeat(10'd100, 1'b0, 1'b1, 100);
      drain(50);
      setGains(12'h200, 12'h100, 12'h100, 12'h080);
      sendBeat(10'd100, 1'b1, 1'b0, 200);
      sendBeat(10'd100, 1'b0, 1'b1, 100);
      sendBeat(10'd100, 1'b0, 1'b0, 100);
      sendBeat(10'd100, 1'b0, 1'b1, 50);
      drain(50);

      // Three 6x3 frames under random input gaps and output backpressure.
      checkLatency = 1'b0;
      randReady    = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 6; c++) begin
               int px;
               int g;
               px = (f * 37 + r * 11 + c * 5 + 3) % 500;
               if (r % 2 == 0) g = (c % 2 == 0) ? 32'h200 : 32'h100;
               else            g = (c % 2 == 0) ? 32'h100 : 32'h080;
               repeat ($urandom_range(0, 2)) @(negedge clock);
               sendBeat(10'(px), (r == 0 && c == 0), (c == 5), modelPx(px, g));
            end
         end
      end
      drain(2000);
      randReady = 1'b0;
      repeat (3) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
